// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port integer register file with a per-register
// pending-write scoreboard. x0 is hard-wired to zero. Reads are
// combinational and can optionally forward same-cycle write data. The busy
// bits track destinations that have been issued but not yet written back.
module reg_file_sb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   r_addr,
    output logic [NUM_RD*DATA_W-1:0]   r_data,
    output logic [NUM_RD-1:0]          r_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [(2**ADDR_W)-1:0]     busy_vec,
    output logic                       wr_conflict
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic                         conflict_q, conflict_d;
    logic [NUM_WR-1:0]            wr_hit;
    logic [ADDR_W-1:0]            rd_a;

    // A write port only counts when it is enabled and not aimed at x0.
    always_comb begin
        wr_hit = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_hit[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0);
        end
    end

    // Next register contents: ports applied in ascending order so the
    // highest-index port wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_hit[p]) begin
                regs_d[wr_addr[p*ADDR_W +: ADDR_W]] = wr_data[p*DATA_W +: DATA_W];
            end
        end
        regs_d[0] = '0;
    end

    // Next scoreboard: writebacks clear first, then an issue sets, so a new
    // producer issued in the same cycle as a writeback keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_hit[p]) begin
                busy_d[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_en && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Flag any two write ports hitting the same nonzero register.
    always_comb begin
        conflict_d = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            for (int q = p + 1; q < NUM_WR; q++) begin
                if (wr_hit[p] && wr_hit[q] &&
                    (wr_addr[p*ADDR_W +: ADDR_W] == wr_addr[q*ADDR_W +: ADDR_W])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Combinational read ports with optional forwarding; the last hitting
    // port in ascending order is the highest-index one and wins.
    // Everything reads as zero while reset is held.
    always_comb begin
        r_data = '0;
        r_busy = '0;
        rd_a   = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_a = r_addr[i*ADDR_W +: ADDR_W];
                r_data[i*DATA_W +: DATA_W] = regs_q[rd_a];
                r_busy[i] = busy_q[rd_a];
                if ((BYPASS != 0) && (rd_a != '0)) begin
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (wr_hit[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_a)) begin
                            r_data[i*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
                            r_busy[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q     <= '0;
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign busy_vec    = busy_q;
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one instance with forwarding, one without, driven
// from the same directed stimulus and checked against an array-based model.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  r_addr = '0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;

  logic [63:0] r_data_b, r_data_n;
  logic [1:0]  r_busy_b, r_busy_n;
  logic [31:0] busy_vec_b, busy_vec_n;
  logic        wr_conflict_b, wr_conflict_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_conf;

  always #5 clk = ~clk;

  reg_file_sb #(.ADDR_W(5), .DATA_W(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(r_data_b), .r_busy(r_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .busy_vec(busy_vec_b), .wr_conflict(wr_conflict_b));

  reg_file_sb #(.ADDR_W(5), .DATA_W(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(r_data_n), .r_busy(r_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .busy_vec(busy_vec_n), .wr_conflict(wr_conflict_n));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected read value: x0 is zero; forwarding takes the highest-index
  // enabled write to the address, otherwise the stored value.
  function automatic logic [31:0] exp_data(input bit byp, input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (byp) begin
      for (int p = 1; p >= 0; p--) begin
        if (wr_en[p] && (wr_addr[p*5 +: 5] == a)) return wr_data[p*32 +: 32];
      end
    end
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (byp) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && (wr_addr[p*5 +: 5] == a)) return 1'b0;
      end
    end
    return m_busy[a];
  endfunction

  // Compare process: each falling edge checks outputs against the model,
  // then advances the model by what the coming rising edge will do.
  initial begin
    logic [63:0] ed_b, ed_n;
    logic [1:0]  eb_b, eb_n;
    logic        nxt_conf;
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_busy = '0;
    m_conf = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_busy = '0;
        m_conf = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        ed_b[i*32 +: 32] = rst ? 32'd0 : exp_data(1'b1, r_addr[i*5 +: 5]);
        ed_n[i*32 +: 32] = rst ? 32'd0 : exp_data(1'b0, r_addr[i*5 +: 5]);
        eb_b[i] = rst ? 1'b0 : exp_busy(1'b1, r_addr[i*5 +: 5]);
        eb_n[i] = rst ? 1'b0 : exp_busy(1'b0, r_addr[i*5 +: 5]);
      end
      chk("r_data_byp", r_data_b, ed_b);
      chk("r_data_nob", r_data_n, ed_n);
      chk("r_busy_byp", {62'd0, r_busy_b}, {62'd0, eb_b});
      chk("r_busy_nob", {62'd0, r_busy_n}, {62'd0, eb_n});
      chk("busy_vec_byp", {32'd0, busy_vec_b}, {32'd0, m_busy});
      chk("busy_vec_nob", {32'd0, busy_vec_n}, {32'd0, m_busy});
      chk("conflict_byp", {63'd0, wr_conflict_b}, {63'd0, m_conf});
      chk("conflict_nob", {63'd0, wr_conflict_n}, {63'd0, m_conf});
      if (!rst) begin
        nxt_conf = wr_en[0] && wr_en[1] && (wr_addr[4:0] == wr_addr[9:5]) && (wr_addr[4:0] != 5'd0);
        for (int p = 0; p < 2; p++) begin
          if (wr_en[p] && (wr_addr[p*5 +: 5] != 5'd0)) begin
            m_regs[wr_addr[p*5 +: 5]] = wr_data[p*32 +: 32];
            m_busy[wr_addr[p*5 +: 5]] = 1'b0;
          end
        end
        if (iss_en && (iss_addr != 5'd0)) m_busy[iss_addr] = 1'b1;
        m_conf = nxt_conf;
      end
    end
  end

  // One cycle of stimulus; returns just after the falling edge so literal
  // checks see this cycle's combinational outputs.
  task automatic cyc(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1, input logic ie,
                     input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    wr_en    = we;
    wr_addr  = {a1, a0};
    wr_data  = {d1, d0};
    iss_en   = ie;
    iss_addr = ia;
    r_addr   = {ra1, ra0};
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, ra0, ra1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("lit_init_busy", {32'd0, busy_vec_b}, 64'd0);
    chk("lit_init_conf", {63'd0, wr_conflict_b}, 64'd0);

    // Preload x3=5, x4=7, then reset mid-cycle.
    cyc(2'b11, 5'd3, 32'd5, 5'd4, 32'd7, 1'b0, 5'd0, 5'd3, 5'd4);
    chk("lit_preload_fwd", r_data_b, {32'd7, 32'd5});
    chk("lit_preload_nofwd", r_data_n, 64'd0);
    idle(5'd3, 5'd4);
    chk("lit_preload_stored", r_data_n, {32'd7, 32'd5});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("lit_rst_rdata", r_data_b, 64'd0);
    chk("lit_rst_busy", {32'd0, busy_vec_b}, 64'd0);
    idle(5'd3, 5'd4);
    chk("lit_after_rst", r_data_n, 64'd0);

    // x0 protection.
    cyc(2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    chk("lit_x0_fwd", r_data_b, 64'd0);
    idle(5'd0, 5'd0);
    chk("lit_x0_data", r_data_n, 64'd0);
    chk("lit_x0_rbusy", {62'd0, r_busy_b}, 64'd0);
    chk("lit_x0_busyvec", {32'd0, busy_vec_b}, 64'd0);

    // Forwarding versus stored value.
    cyc(2'b01, 5'd3, 32'h1, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc(2'b01, 5'd3, 32'h12, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
    chk("lit_byp_new", {32'd0, r_data_b[31:0]}, 64'h12);
    chk("lit_nob_old", {32'd0, r_data_n[31:0]}, 64'h1);
    idle(5'd3, 5'd4);
    chk("lit_nob_next", {32'd0, r_data_n[31:0]}, 64'h12);

    // Write collision on x7: port 1 wins, one-cycle conflict pulse.
    cyc(2'b11, 5'd7, 32'hA, 5'd7, 32'hB, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("lit_coll_fwd", {32'd0, r_data_b[31:0]}, 64'hB);
    chk("lit_coll_conf_now", {63'd0, wr_conflict_b}, 64'd0);
    idle(5'd7, 5'd0);
    chk("lit_coll_data", {32'd0, r_data_n[31:0]}, 64'hB);
    chk("lit_coll_conf", {63'd0, wr_conflict_n}, 64'd1);
    idle(5'd7, 5'd0);
    chk("lit_coll_conf_end", {63'd0, wr_conflict_b}, 64'd0);

    // Scoreboard flow on x5.
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0);
    chk("lit_sb_not_yet", {62'd0, r_busy_b}, 64'd0);
    idle(5'd5, 5'd0);
    chk("lit_sb_vec", {63'd0, busy_vec_b[5]}, 64'd1);
    chk("lit_sb_rbusy", {63'd0, r_busy_n[0]}, 64'd1);
    cyc(2'b01, 5'd5, 32'h99, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
    chk("lit_sb_wb_byp", {63'd0, r_busy_b[0]}, 64'd0);
    chk("lit_sb_wb_nob", {63'd0, r_busy_n[0]}, 64'd1);
    chk("lit_sb_wb_data", {32'd0, r_data_b[31:0]}, 64'h99);
    idle(5'd5, 5'd0);
    chk("lit_sb_cleared", {63'd0, busy_vec_b[5]}, 64'd0);

    // Set wins over clear on x6; re-issue while busy needs one writeback.
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 5'd0);
    cyc(2'b01, 5'd6, 32'h66, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 5'd0);
    idle(5'd6, 5'd0);
    chk("lit_setwin_busy", {63'd0, busy_vec_b[6]}, 64'd1);
    chk("lit_setwin_data", {32'd0, r_data_n[31:0]}, 64'h66);
    cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6, 5'd0);
    cyc(2'b01, 5'd6, 32'h77, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd0);
    idle(5'd6, 5'd0);
    chk("lit_reissue_clear", {63'd0, busy_vec_b[6]}, 64'd0);

    // Write to a register that is not busy, via port 1 only.
    cyc(2'b10, 5'd0, 32'd0, 5'd9, 32'h123, 1'b0, 5'd0, 5'd0, 5'd9);
    idle(5'd0, 5'd9);
    chk("lit_free_write", {32'd0, r_data_n[63:32]}, 64'h123);
    chk("lit_free_busy", {63'd0, busy_vec_n[9]}, 64'd0);

    // A short sweep of mixed writes, issues and reads for the model to cover.
    for (int k = 1; k < 12; k++) begin
      cyc(2'(k % 4), 5'(k + 10), 32'(k * 3), 5'(k + 11), 32'(k * 5),
          1'(k % 2), 5'(k + 12), 5'(k + 10), 5'(k + 12));
    end
    idle(5'd14, 5'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
